clk_timer_stats: RTL and testbench

//   Downstream consumer of the CLK_Timer interval measurement.
//   - Collects each final 8-bit signal1->signal2 interval, one per in_valid strobe.
//   - Reduces every WINDOW samples to min/max/sum/count plus a saturated-sample count.
//   - Presents each window result through a valid/ready handshake to readout logic
//     (register map / Aurora framing). Single clock domain, shared with the timer.

---
 rtl/clk_timer_stats.sv | 114 +++++++++++
 tb/tb_clk_timer_stats.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/clk_timer_stats.sv
// Windowed min/max/sum/saturation statistics over CLK_Timer interval samples,
// handed to readout logic through a single-entry valid/ready result register.
module clk_timer_stats #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    clear,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_W-1:0]       res_min,
  output logic [DATA_W-1:0]       res_max,
  output logic [DATA_W+CNT_W-1:0] res_sum,
  output logic [CNT_W-1:0]        res_count,
  output logic [CNT_W-1:0]        res_nsat,
  output logic                    overflow
);

  localparam int SUM_W = DATA_W + CNT_W;
  localparam logic [DATA_W-1:0] SAT  = '1;
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(WINDOW - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state;
  logic [DATA_W-1:0] acc_min, acc_max;
  logic [SUM_W-1:0]  acc_sum;
  logic [CNT_W-1:0]  acc_cnt, acc_nsat;

  logic              accept, complete, load;
  logic [DATA_W-1:0] nxt_min, nxt_max;
  logic [SUM_W-1:0]  nxt_sum;
  logic [CNT_W-1:0]  nxt_cnt, nxt_nsat;

  // Accumulator values including the current sample; these are also the
  // result of a window that completes this cycle.
  always_comb begin
    accept   = in_valid && !clear;
    complete = accept && (acc_cnt == LAST);
    load     = complete && ((state == EMPTY) || res_ready);
    nxt_min  = (in_data < acc_min) ? in_data : acc_min;
    nxt_max  = (in_data > acc_max) ? in_data : acc_max;
    nxt_sum  = acc_sum + SUM_W'(in_data);
    nxt_cnt  = acc_cnt + CNT_W'(1);
    nxt_nsat = acc_nsat + ((in_data == SAT) ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (reset || clear || complete) begin
      acc_min  <= SAT;
      acc_max  <= '0;
      acc_sum  <= '0;
      acc_cnt  <= '0;
      acc_nsat <= '0;
    end else if (accept) begin
      acc_min  <= nxt_min;
      acc_max  <= nxt_max;
      acc_sum  <= nxt_sum;
      acc_cnt  <= nxt_cnt;
      acc_nsat <= nxt_nsat;
    end
  end

  // A window finishing while the previous result is still unconsumed is
  // dropped rather than overwriting results the reader may be mid-way through.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      res_valid <= 1'b0;
      res_min   <= '0;
      res_max   <= '0;
      res_sum   <= '0;
      res_count <= '0;
      res_nsat  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        res_min   <= nxt_min;
        res_max   <= nxt_max;
        res_sum   <= nxt_sum;
        res_count <= nxt_cnt;
        res_nsat  <= nxt_nsat;
      end
      if (clear) begin
        overflow <= 1'b0;
      end else if ((state == FULL) && complete && !res_ready) begin
        overflow <= 1'b1;
      end
      case (state)
        EMPTY: begin
          if (complete) begin
            state     <= FULL;
            res_valid <= 1'b1;
          end
        end
        FULL: begin
          if (res_ready && !complete) begin
            state     <= EMPTY;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_timer_stats.sv
// Directed self-checking bench for clk_timer_stats: WINDOW=4 instance for the
// main scenarios plus a WINDOW=1 instance for the single-sample window case.
module tb_clk_timer_stats;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, clear, res_ready;
  logic [7:0]  in_data;
  logic        res_valid, overflow;
  logic [7:0]  res_min, res_max;
  logic [23:0] res_sum;
  logic [15:0] res_count, res_nsat;

  logic        in_valid1, res_ready1;
  logic [7:0]  in_data1;
  logic        res_valid1, overflow1;
  logic [7:0]  res_min1, res_max1;
  logic [23:0] res_sum1;
  logic [15:0] res_count1, res_nsat1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  clk_timer_stats #(.DATA_W(8), .CNT_W(16), .WINDOW(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .clear(clear), .res_valid(res_valid), .res_ready(res_ready),
    .res_min(res_min), .res_max(res_max), .res_sum(res_sum),
    .res_count(res_count), .res_nsat(res_nsat), .overflow(overflow)
  );

  clk_timer_stats #(.DATA_W(8), .CNT_W(16), .WINDOW(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_data(in_data1),
    .clear(1'b0), .res_valid(res_valid1), .res_ready(res_ready1),
    .res_min(res_min1), .res_max(res_max1), .res_sum(res_sum1),
    .res_count(res_count1), .res_nsat(res_nsat1), .overflow(overflow1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // One clock with the given strobe/data/clear; outputs are sampled 1ns after the edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic sendSample(input logic [7:0] d);
    applyStimulus(1'b1, d, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0; res_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; res_ready1 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    checkOutput("reset_valid", res_valid, 0);
    checkOutput("reset_ovf", overflow, 0);
    checkOutput("reset_min", res_min, 0);
    checkOutput("reset_sum", res_sum, 0);

    // 1: basic window
    res_ready = 1'b1;
    sendSample(5); sendSample(3); sendSample(9);
    checkOutput("t1_valid_early", res_valid, 0);
    sendSample(7);
    checkOutput("t1_valid", res_valid, 1);
    checkOutput("t1_min", res_min, 3);
    checkOutput("t1_max", res_max, 9);
    checkOutput("t1_sum", res_sum, 24);
    checkOutput("t1_count", res_count, 4);
    checkOutput("t1_nsat", res_nsat, 0);
    idle();
    checkOutput("t1_consumed", res_valid, 0);

    // 2: second window dropped while first is held
    res_ready = 1'b0;
    sendSample(1); sendSample(2); sendSample(3); sendSample(4);
    checkOutput("t2_valid", res_valid, 1);
    checkOutput("t2_ovf_early", overflow, 0);
    for (int i = 0; i < 4; i++) sendSample(10);
    checkOutput("t2_ovf", overflow, 1);
    checkOutput("t2_min", res_min, 1);
    checkOutput("t2_max", res_max, 4);
    checkOutput("t2_sum", res_sum, 10);
    res_ready = 1'b1;
    idle();
    checkOutput("t2_consumed", res_valid, 0);
    checkOutput("t2_keep_sum", res_sum, 10);
    checkOutput("t2_ovf_sticky", overflow, 1);

    // 3: consume and reload on the same edge
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("t3_ovf_clear", overflow, 0);
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) sendSample(1);
    checkOutput("t3_first_sum", res_sum, 4);
    sendSample(8); sendSample(8); sendSample(8);
    res_ready = 1'b1;
    sendSample(8);
    checkOutput("t3_valid", res_valid, 1);
    checkOutput("t3_sum", res_sum, 32);
    checkOutput("t3_ovf", overflow, 0);
    idle();
    checkOutput("t3_consumed", res_valid, 0);

    // 4: extremes and saturated samples
    sendSample(255); sendSample(0); sendSample(255); sendSample(6);
    checkOutput("t4_min", res_min, 0);
    checkOutput("t4_max", res_max, 255);
    checkOutput("t4_sum", res_sum, 516);
    checkOutput("t4_nsat", res_nsat, 2);
    idle();

    // 5a: clear mid-window, with a strobe that must be ignored
    sendSample(4); sendSample(4);
    applyStimulus(1'b1, 8'd99, 1'b1);
    sendSample(1); sendSample(2); sendSample(3);
    checkOutput("t5c_valid_early", res_valid, 0);
    sendSample(4);
    checkOutput("t5c_valid", res_valid, 1);
    checkOutput("t5c_min", res_min, 1);
    checkOutput("t5c_max", res_max, 4);
    checkOutput("t5c_sum", res_sum, 10);
    idle();

    // 5b: reset mid-window
    sendSample(4); sendSample(4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("t5r_sum_cleared", res_sum, 0);
    sendSample(1); sendSample(2); sendSample(3);
    checkOutput("t5r_valid_early", res_valid, 0);
    sendSample(4);
    checkOutput("t5r_valid", res_valid, 1);
    checkOutput("t5r_min", res_min, 1);
    checkOutput("t5r_max", res_max, 4);
    checkOutput("t5r_sum", res_sum, 10);

    // 6: WINDOW=1, back-to-back samples
    res_ready1 = 1'b1;
    in_valid1 = 1'b1;
    in_data1  = 8'd7;
    @(posedge clk);
    #1;
    checkOutput("t6_valid_a", res_valid1, 1);
    checkOutput("t6_sum_a", res_sum1, 7);
    checkOutput("t6_min_a", res_min1, 7);
    checkOutput("t6_max_a", res_max1, 7);
    in_data1 = 8'd9;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    checkOutput("t6_valid_b", res_valid1, 1);
    checkOutput("t6_sum_b", res_sum1, 9);
    checkOutput("t6_count_b", res_count1, 1);
    checkOutput("t6_ovf", overflow1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
